// File: rtl/iman_periodo.sv
// iman_periodo: magnet-contact synchronizer/debouncer, impulse generator and wheel period meter.
// Define IMAN_RECHAZO_MIN_EN to drop impulses closer than MIN_PERIOD cycles to the previous one.
module iman_periodo #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned TIMEOUT         = 16777215,
  parameter int unsigned MIN_PERIOD      = 50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iman,
  output logic        impulso,
  output logic [23:0] periodo,
  output logic        periodo_valid,
  output logic        detenido,
  output logic [15:0] vueltas
);

  localparam int             DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]    TO      = 24'(TIMEOUT);

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT < 2 || TIMEOUT > 32'h00FF_FFFF || MIN_PERIOD < 1)
  begin : g_bad_param
    $error("iman_periodo: parameter out of range");
  end

  typedef enum logic {IDLE = 1'b0, MIDIENDO = 1'b1} state_t;

  logic [1:0]     r_sync;
  logic           w_sync;
  logic [DBW-1:0] r_db_cnt;
  logic           r_filt, r_filt_q;
  logic           w_rise, w_too_soon, w_accept;

  state_t         r_state, w_state_nx;
  logic [23:0]    r_cnt, w_cnt_nx, w_cnt_inc;
  logic [23:0]    r_periodo, w_periodo_nx;
  logic           r_pv, w_pv_nx;
  logic           r_det, w_det_nx;
  logic           r_imp;
  logic [15:0]    r_vueltas;

  // Two-flop synchronizer on the raw contact
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], iman};
  end
  assign w_sync = r_sync[1];

  // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_db_cnt <= '0;
      r_filt   <= 1'b0;
      r_filt_q <= 1'b0;
    end else begin
      r_filt_q <= r_filt;
      if (w_sync == r_filt) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_filt   <= w_sync;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DBW'(1);
      end
    end
  end
  assign w_rise = r_filt & ~r_filt_q;

`ifdef IMAN_RECHAZO_MIN_EN
  localparam logic [23:0] MIN_LAST = 24'(MIN_PERIOD - 1);
  assign w_too_soon = (r_state == MIDIENDO) && (r_cnt < MIN_LAST);
`else
  assign w_too_soon = 1'b0;
`endif
  assign w_accept = w_rise & ~w_too_soon;

  // r_cnt never exceeds TO-1 while measuring, so cnt+1 is the distance to the last impulse
  assign w_cnt_inc = (r_cnt == TO) ? TO : r_cnt + 24'd1;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_periodo_nx = r_periodo;
    w_pv_nx      = 1'b0;
    w_det_nx     = r_det;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nx = MIDIENDO;
          w_cnt_nx   = '0;
          w_det_nx   = 1'b0;
        end
      end
      MIDIENDO: begin
        w_cnt_nx = w_cnt_inc;
        if (w_accept) begin
          w_periodo_nx = w_cnt_inc;
          w_pv_nx      = 1'b1;
          w_cnt_nx     = '0;
        end else if (w_cnt_inc == TO) begin
          w_state_nx   = IDLE;
          w_det_nx     = 1'b1;
          w_periodo_nx = '0;
          w_cnt_nx     = '0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_periodo <= '0;
      r_pv      <= 1'b0;
      r_det     <= 1'b1;
      r_imp     <= 1'b0;
      r_vueltas <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_periodo <= w_periodo_nx;
      r_pv      <= w_pv_nx;
      r_det     <= w_det_nx;
      r_imp     <= w_accept;
      r_vueltas <= r_vueltas + {15'd0, w_accept};
    end
  end

  assign impulso       = r_imp;
  assign periodo       = r_periodo;
  assign periodo_valid = r_pv;
  assign detenido      = r_det;
  assign vueltas       = r_vueltas;

endmodule

// File: tb/tb_iman_periodo.sv
// Self-checking bench for iman_periodo: directed scenarios plus random contact
// waveforms checked against a timestamp-based reference model.
module tb_iman_periodo;
  localparam int D = 4, T = 100, M = 10;
`ifdef IMAN_RECHAZO_MIN_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif

  logic clock = 1'b0, reset_n = 1'b0, iman = 1'b0, iman2 = 1'b0;
  logic impulso, periodo_valid, detenido;
  logic [23:0] periodo;
  logic [15:0] vueltas;
  logic impulso2, periodo_valid2, detenido2;
  logic [23:0] periodo2;
  logic [15:0] vueltas2;
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  iman_periodo #(.DEBOUNCE_CYCLES(D), .TIMEOUT(T), .MIN_PERIOD(M)) dut (
    .clock(clock), .reset_n(reset_n), .iman(iman), .impulso(impulso), .periodo(periodo),
    .periodo_valid(periodo_valid), .detenido(detenido), .vueltas(vueltas));

  // Short debounce so that filtered edges 6 cycles apart are reachable
  iman_periodo #(.DEBOUNCE_CYCLES(2), .TIMEOUT(T), .MIN_PERIOD(M)) dut2 (
    .clock(clock), .reset_n(reset_n), .iman(iman2), .impulso(impulso2), .periodo(periodo2),
    .periodo_valid(periodo_valid2), .detenido(detenido2), .vueltas(vueltas2));

  // Reference model: edge counter + timestamps of level rise and last accepted impulse
  logic m_d1, m_d2, m_lvl, m_imp, m_pv, m_det, m_armed, m_cand, m_acc;
  int m_run, m_edge, m_rise_at, m_tlast, m_dist;
  logic [23:0] m_per;
  logic [15:0] m_vue;

  assign m_cand = (m_rise_at == m_edge - 1);
  assign m_dist = m_edge - m_tlast;
  assign m_acc  = m_cand && !(REJ && m_armed && m_dist < M);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_d1 <= 0; m_d2 <= 0; m_lvl <= 0; m_run <= 0; m_edge <= 0; m_rise_at <= -100;
      m_tlast <= 0; m_armed <= 0; m_imp <= 0; m_pv <= 0; m_det <= 1; m_per <= 0; m_vue <= 0;
    end else begin
      m_d1 <= iman;
      m_d2 <= m_d1;
      if (m_d2 != m_lvl) begin
        if (m_run + 1 == D) begin
          m_lvl <= m_d2;
          m_run <= 0;
          if (m_d2) m_rise_at <= m_edge;
        end else m_run <= m_run + 1;
      end else m_run <= 0;
      m_imp <= m_acc;
      m_pv  <= m_acc && m_armed;
      if (m_acc) begin
        m_vue   <= m_vue + 16'd1;
        m_tlast <= m_edge;
        if (m_armed) m_per <= 24'(m_dist);
        else begin m_armed <= 1; m_det <= 0; end
      end else if (m_armed && m_dist >= T) begin
        m_armed <= 0; m_det <= 1; m_per <= '0;
      end
      m_edge <= m_edge + 1;
    end
  end

  task automatic step(input logic v, input logic v2);
    iman = v; iman2 = v2;
    @(negedge clock);
  endtask

  task automatic do_reset;
    iman = 0; iman2 = 0; reset_n = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
    @(negedge clock);
  endtask

  task automatic test_reset;
    iman = 0; iman2 = 0; reset_n = 0;
    @(negedge clock);
    total++;
    if ({impulso, periodo_valid, detenido, periodo, vueltas} !== {1'b0, 1'b0, 1'b1, 24'd0, 16'd0}) begin
      bad++; $display("FAIL reset_values got imp=%b pv=%b det=%b per=%0d vue=%0d exp 0 0 1 0 0",
                      impulso, periodo_valid, detenido, periodo, vueltas);
    end
    reset_n = 1;
    @(negedge clock);
  endtask

  task automatic test_debounce;
    int n_imp;
    n_imp = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin step(1, 0); n_imp += impulso; end
    for (int i = 0; i < 12; i++) begin step(0, 0); n_imp += impulso; end
    total++;
    if (n_imp !== 0) begin bad++; $display("FAIL short_glitch got %0d impulsos exp 0", n_imp); end
    for (int i = 1; i <= 20; i++) begin
      step(1, 0);
      total++;
      if (impulso !== (i == 7)) begin
        bad++; $display("FAIL latency cycle=%0d got imp=%b exp %b", i, impulso, (i == 7));
      end
    end
    total++;
    if ({vueltas, detenido} !== {16'd1, 1'b0}) begin
      bad++; $display("FAIL first_impulse got vue=%0d det=%b exp 1 0", vueltas, detenido);
    end
    n_imp = 0;
    for (int i = 0; i < 12; i++) begin step(0, 0); n_imp += impulso; end
    total++;
    if (n_imp !== 0 || vueltas !== 16'd1) begin
      bad++; $display("FAIL falling_edge got imp=%0d vue=%0d exp 0 1", n_imp, vueltas);
    end
  endtask

  task automatic test_period;
    int npv;
    npv = 0;
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 40; i++) begin
        step(i < 10, 0);
        total++;
        if ({impulso, periodo_valid, detenido, periodo, vueltas} !== {m_imp, m_pv, m_det, m_per, m_vue}) begin
          bad++; $display("FAIL period_model got per=%0d pv=%b vue=%0d exp per=%0d pv=%b vue=%0d",
                          periodo, periodo_valid, vueltas, m_per, m_pv, m_vue);
        end
        if (periodo_valid) begin
          npv++;
          total++;
          if (periodo !== 24'd40) begin bad++; $display("FAIL period_value got %0d exp 40", periodo); end
        end
      end
    total++;
    if (npv !== 2 || vueltas !== 16'd3) begin
      bad++; $display("FAIL period_count got pv=%0d vue=%0d exp 2 3", npv, vueltas);
    end
  endtask

  task automatic test_timeout;
    int s, npv, nimp;
    s = -1; npv = 0; nimp = 0;
    do_reset();
    for (int i = 1; i <= 130; i++) begin
      step(i <= 10, 0);
      if (impulso && s < 0) s = i;
      if (s > 0 && i == s + 99) begin
        total++;
        if (detenido !== 1'b0) begin bad++; $display("FAIL timeout_early got det=%b exp 0", detenido); end
      end
      if (s > 0 && i == s + 100) begin
        total++;
        if ({detenido, periodo, periodo_valid} !== {1'b1, 24'd0, 1'b0}) begin
          bad++; $display("FAIL timeout got det=%b per=%0d pv=%b exp 1 0 0", detenido, periodo, periodo_valid);
        end
      end
    end
    total++;
    if (s !== 7) begin bad++; $display("FAIL timeout_arm got cycle=%0d exp 7", s); end
    for (int i = 1; i <= 20; i++) begin
      step(i <= 10, 0);
      npv += periodo_valid; nimp += impulso;
    end
    total++;
    if (nimp !== 1 || npv !== 0 || detenido !== 1'b0) begin
      bad++; $display("FAIL rearm got imp=%0d pv=%0d det=%b exp 1 0 0", nimp, npv, detenido);
    end
  endtask

  task automatic test_boundary;
    do_reset();
    for (int i = 1; i <= 115; i++) begin
      step((i <= 10) || (i > 100 && i <= 110), 0);
      if (i == 106) begin
        total++;
        if (detenido !== 1'b0) begin bad++; $display("FAIL boundary_pre got det=%b exp 0", detenido); end
      end
      if (i == 107) begin
        total++;
        if ({impulso, periodo_valid, detenido, periodo} !== {1'b1, 1'b1, 1'b0, 24'd100}) begin
          bad++; $display("FAIL boundary got imp=%b pv=%b det=%b per=%0d exp 1 1 0 100",
                          impulso, periodo_valid, detenido, periodo);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    int npv, nimp;
    npv = 0; nimp = 0;
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0);
    #2 reset_n = 0;
    #1;
    total++;
    if ({impulso, periodo_valid, detenido, periodo, vueltas} !== {1'b0, 1'b0, 1'b1, 24'd0, 16'd0}) begin
      bad++; $display("FAIL reset_debounce got imp=%b pv=%b det=%b per=%0d vue=%0d exp 0 0 1 0 0",
                      impulso, periodo_valid, detenido, periodo, vueltas);
    end
    @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < 12; i++) begin step(i < 3, 0); nimp += impulso; end
    total++;
    if (nimp !== 0) begin bad++; $display("FAIL reset_debounce_discard got imp=%0d exp 0", nimp); end
    for (int i = 0; i < 60; i++) step((i < 10) || (i >= 40 && i < 50), 0);
    total++;
    if ({vueltas, periodo, detenido} !== {16'd2, 24'd40, 1'b0}) begin
      bad++; $display("FAIL pre_reset got vue=%0d per=%0d det=%b exp 2 40 0", vueltas, periodo, detenido);
    end
    #3 reset_n = 0;
    #1;
    total++;
    if ({impulso, periodo_valid, detenido, periodo, vueltas} !== {1'b0, 1'b0, 1'b1, 24'd0, 16'd0}) begin
      bad++; $display("FAIL reset_measure got imp=%b pv=%b det=%b per=%0d vue=%0d exp 0 0 1 0 0",
                      impulso, periodo_valid, detenido, periodo, vueltas);
    end
    @(negedge clock);
    reset_n = 1;
    nimp = 0;
    for (int i = 1; i <= 20; i++) begin
      step(i <= 10, 0);
      npv += periodo_valid; nimp += impulso;
    end
    total++;
    if (nimp !== 1 || npv !== 0 || vueltas !== 16'd1 || periodo !== 24'd0) begin
      bad++; $display("FAIL post_reset_arm got imp=%0d pv=%0d vue=%0d per=%0d exp 1 0 1 0",
                      nimp, npv, vueltas, periodo);
    end
  endtask

  task automatic test_min_period;
    int nimp;
    logic [23:0] pers[$];
    nimp = 0;
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      step(0, (i <= 3) || (i >= 7 && i <= 9) || (i >= 41 && i <= 43));
      nimp += impulso2;
      if (periodo_valid2) pers.push_back(periodo2);
    end
    total++;
    if (nimp !== (REJ ? 2 : 3) || vueltas2 !== (REJ ? 16'd2 : 16'd3)) begin
      bad++; $display("FAIL min_period_count got imp=%0d vue=%0d exp %0d", nimp, vueltas2, REJ ? 2 : 3);
    end
    total++;
    if (pers.size() < 1 || pers[0] !== (REJ ? 24'd40 : 24'd6)) begin
      bad++; $display("FAIL min_period_value got n=%0d first=%0d exp %0d", pers.size(),
                      (pers.size() > 0) ? pers[0] : 24'd0, REJ ? 40 : 6);
    end
  endtask

  task automatic test_random;
    logic lvl;
    int len;
    lvl = 0;
    do_reset();
    for (int r = 0; r < 60; r++) begin
      len = $urandom_range(1, 70);
      lvl = ~lvl;
      for (int i = 0; i < len; i++) begin
        step(lvl, 0);
        total++;
        if ({impulso, periodo_valid, detenido, periodo, vueltas} !== {m_imp, m_pv, m_det, m_per, m_vue}) begin
          bad++; $display("FAIL random got imp=%b pv=%b det=%b per=%0d vue=%0d exp imp=%b pv=%b det=%b per=%0d vue=%0d",
                          impulso, periodo_valid, detenido, periodo, vueltas, m_imp, m_pv, m_det, m_per, m_vue);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_period();
    test_timeout();
    test_boundary();
    test_async_reset();
    test_min_period();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iman_periodo.md
IMAN_PERIODO -- requirements
Module: iman_periodo

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 65536: consecutive stable cycles before the filtered magnet level changes.
REQ-002 SHALL have parameter TIMEOUT, default 16777215: period count at which the wheel is declared stopped.
REQ-003 SHALL have parameter MIN_PERIOD, default 50000: minimum accepted cycles between impulses; used only under IMAN_RECHAZO_MIN_EN.
REQ-004 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port iman  input  1  raw asynchronous reed/hall magnet contact.
REQ-007 SHALL have port impulso  output  1  one-cycle pulse per accepted magnet rising edge; feeds the displacement stage.
REQ-008 SHALL have port periodo  output  24  clock cycles between the last two accepted impulses.
REQ-009 SHALL have port periodo_valid  output  1  one-cycle strobe when periodo updates.
REQ-010 SHALL have port detenido  output  1  high while the wheel is considered stopped.
REQ-011 SHALL have port vueltas  output  16  accepted impulse count, wraps 65535->0.

Function
REQ-012 SHALL pass iman through a 2-flop synchronizer before any other use.
REQ-013 SHALL change the filtered level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion resets the stability counter to 0.
REQ-014 SHALL assert impulso for exactly one cycle, in the cycle after the filtered level rises 0->1; falling edges produce nothing.
REQ-015 SHALL have fixed latency DEBOUNCE_CYCLES+3 cycles from the first cycle iman is high and stable to impulso.
REQ-016 SHALL implement states IDLE (no reference edge) and MIDIENDO (reference edge held, counting).
REQ-017 SHALL in IDLE on impulso: go to MIDIENDO, clear the period counter, deassert detenido, leave periodo unchanged, no periodo_valid.
REQ-018 SHALL in MIDIENDO increment the period counter each cycle, saturating at TIMEOUT.
REQ-019 SHALL in MIDIENDO on impulso: load periodo with the exact cycle distance between the two impulso pulses, pulse periodo_valid in the same cycle, restart the counter, stay in MIDIENDO.
REQ-020 SHALL in MIDIENDO when the counter reaches TIMEOUT without impulso: go to IDLE, set detenido, set periodo to 0, no periodo_valid.
REQ-021 SHALL give impulso priority when it coincides with the counter reaching TIMEOUT: periodo=TIMEOUT, periodo_valid=1, stay in MIDIENDO.
REQ-022 SHALL increment vueltas by 1 on every accepted impulso, with modulo-2^16 wrap.

Reset
REQ-023 SHALL on reset_n low, asynchronously and regardless of activity: state IDLE, impulso=0, periodo=0, periodo_valid=0, detenido=1, vueltas=0, synchronizer/filter/counters=0.
REQ-024 SHALL discard an in-progress debounce or measurement on mid-operation reset; the first impulso after release only arms (REQ-017).

Configuration
REQ-025 SHALL, with IMAN_RECHAZO_MIN_EN defined, drop any filtered rising edge arriving in MIDIENDO with counter < MIN_PERIOD-1 (distance < MIN_PERIOD): no impulso, no vueltas change, no periodo_valid, counter keeps running.
REQ-026 SHALL, without IMAN_RECHAZO_MIN_EN, accept every filtered rising edge; MIN_PERIOD is unused and adds no logic.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT=100, MIN_PERIOD=10)
REQ-027 SHALL test: iman high for 3 cycles then low -> no impulso; iman high 20 cycles -> one impulso 7 cycles after rise, vueltas=1, detenido=0.
REQ-028 SHALL test: accepted edges 40 cycles apart, three times -> periodo_valid on 2nd and 3rd impulso, periodo=40 both, vueltas=3.
REQ-029 SHALL test: one impulso then silence -> 100 cycles later detenido=1, periodo=0, state IDLE; next impulso gives no periodo_valid.
REQ-030 SHALL test: impulso in the cycle the counter hits 100 -> periodo=100, periodo_valid=1, detenido stays 0.
REQ-031 SHALL test: reset_n pulsed low mid-debounce and mid-measurement -> all outputs at REQ-023 values immediately, asynchronously.
REQ-032 SHALL test, with IMAN_RECHAZO_MIN_EN: edges 6 cycles apart -> second dropped; next edge 40 cycles after first -> periodo=40, vueltas=2. Without it: second edge accepted, periodo=6.
